// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - button count and index map shared by the conditioner and calculator top
package calc_pkg;

    localparam int NUM_BTNS = 5;

    localparam int BTN_C = 0;
    localparam int BTN_L = 1;
    localparam int BTN_U = 2;
    localparam int BTN_R = 3;
    localparam int BTN_D = 4;

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - one button channel: two-flop synchroniser, stability counter, level and rise pulse
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_level,
    output logic o_pulse
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_s1;
    logic             r_s2;
    logic             r_level;
    logic             r_pulse;
    logic [CNT_W-1:0] r_cnt;

    logic w_differ;
    logic w_flip;

    assign w_differ = (r_s2 != r_level);
    assign w_flip   = w_differ && (r_cnt == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_level <= 1'b0;
            r_cnt   <= '0;
            r_pulse <= 1'b0;
        end else begin
            r_s1 <= i_btn;
            r_s2 <= r_s1;
            // Any sample matching the current level restarts the stability window.
            if (!w_differ) begin
                r_cnt <= '0;
            end else if (w_flip) begin
                r_level <= r_s2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            r_pulse <= w_flip && !r_level;
        end
    end

    assign o_level = r_level;
    assign o_pulse = r_pulse;

endmodule

// File: rtl/btn_conditioner.sv
// rtl/btn_conditioner.sv - debounces the five board push-buttons into levels and rise pulses
module btn_conditioner
    import calc_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_BTNS-1:0] btn_in,
    output logic [NUM_BTNS-1:0] btn_level,
    output logic [NUM_BTNS-1:0] btn_pulse
);

    logic [NUM_BTNS-1:0] w_level;
    logic [NUM_BTNS-1:0] w_pulse;

    for (genvar i = 0; i < NUM_BTNS; i++) begin : g_chan
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk    (clk),
            .rst    (rst),
            .i_btn  (btn_in[i]),
            .o_level(w_level[i]),
            .o_pulse(w_pulse[i])
        );
    end

    assign btn_level = w_level;
    assign btn_pulse = w_pulse;

endmodule

// File: tb/tb_btn_conditioner.sv
// tb/tb_btn_conditioner.sv - directed checks of btn_conditioner at DEBOUNCE_CYCLES=4 and =1
module tb_btn_conditioner;

    logic       clk;
    logic       rst;
    logic [4:0] btn_in;
    logic [4:0] btn_level;
    logic [4:0] btn_pulse;
    logic [4:0] btn_in1;
    logic [4:0] btn_level1;
    logic [4:0] btn_pulse1;

    int checks;
    int errors;

    btn_conditioner #(.DEBOUNCE_CYCLES(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_in   (btn_in),
        .btn_level(btn_level),
        .btn_pulse(btn_pulse)
    );

    btn_conditioner #(.DEBOUNCE_CYCLES(1)) dut1 (
        .clk      (clk),
        .rst      (rst),
        .btn_in   (btn_in1),
        .btn_level(btn_level1),
        .btn_pulse(btn_pulse1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string name, input int edge_no,
                              input logic [4:0] exp_level, input logic [4:0] exp_pulse);
        checks++;
        if (btn_level !== exp_level || btn_pulse !== exp_pulse) begin
            errors++;
            $display("FAIL %s edge %0d: level=%b pulse=%b, expected level=%b pulse=%b",
                     name, edge_no, btn_level, btn_pulse, exp_level, exp_pulse);
        end
    endtask

    task automatic test_reset;
        btn_in = 5'b11111;
        tick();
        #2 rst = 1'b1;
        #1;
        checks++;
        if (btn_level !== 5'b0 || btn_pulse !== 5'b0) begin
            errors++;
            $display("FAIL reset_async: level=%b pulse=%b, expected 00000/00000", btn_level, btn_pulse);
        end
        tick();
        tick();
        expect_out("reset_hold", 0, 5'b00000, 5'b00000);
        rst = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k < 6)       expect_out("reset_release", k, 5'b00000, 5'b00000);
            else if (k == 6) expect_out("reset_release", k, 5'b11111, 5'b11111);
            else             expect_out("reset_release", k, 5'b11111, 5'b00000);
        end
        btn_in = 5'b00000;
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k < 6) expect_out("release_all", k, 5'b11111, 5'b00000);
            else       expect_out("release_all", k, 5'b00000, 5'b00000);
        end
    endtask

    task automatic test_clean_press;
        btn_in[4] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k < 6)       expect_out("press_btnd", k, 5'b00000, 5'b00000);
            else if (k == 6) expect_out("press_btnd", k, 5'b10000, 5'b10000);
            else             expect_out("press_btnd", k, 5'b10000, 5'b00000);
        end
        btn_in[4] = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k < 6) expect_out("release_btnd", k, 5'b10000, 5'b00000);
            else       expect_out("release_btnd", k, 5'b00000, 5'b00000);
        end
    endtask

    task automatic test_bounce;
        logic [7:0] pattern;
        pattern = 8'b0111_0111;
        for (int k = 1; k <= 16; k++) begin
            btn_in[2] = (k <= 8) ? pattern[k-1] : 1'b1;
            tick();
            if (k < 14)       expect_out("bounce_btnu", k, 5'b00000, 5'b00000);
            else if (k == 14) expect_out("bounce_btnu", k, 5'b00100, 5'b00100);
            else              expect_out("bounce_btnu", k, 5'b00100, 5'b00000);
        end
        btn_in[2] = 1'b0;
        for (int k = 1; k <= 6; k++) tick();
        expect_out("bounce_release", 6, 5'b00000, 5'b00000);
    endtask

    task automatic test_reset_mid_count;
        btn_in[0] = 1'b1;
        for (int k = 1; k <= 4; k++) tick();
        checks++;
        if (dut.g_chan[0].u_debounce.r_cnt !== 3'd2) begin
            errors++;
            $display("FAIL midcount_cnt_before: cnt=%0d, expected 2", dut.g_chan[0].u_debounce.r_cnt);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (dut.g_chan[0].u_debounce.r_cnt !== 3'd0 || btn_level !== 5'b0) begin
            errors++;
            $display("FAIL midcount_reset: cnt=%0d level=%b, expected 0/00000",
                     dut.g_chan[0].u_debounce.r_cnt, btn_level);
        end
        tick();
        rst = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k < 6)       expect_out("midcount_restart", k, 5'b00000, 5'b00000);
            else if (k == 6) expect_out("midcount_restart", k, 5'b00001, 5'b00001);
            else             expect_out("midcount_restart", k, 5'b00001, 5'b00000);
        end
        btn_in[0] = 1'b0;
        for (int k = 1; k <= 6; k++) tick();
        expect_out("midcount_release", 6, 5'b00000, 5'b00000);
    endtask

    task automatic test_independence;
        btn_in[1] = 1'b1;
        btn_in[3] = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            btn_in[0] = k[0];
            tick();
            if (k < 6)       expect_out("indep", k, 5'b00000, 5'b00000);
            else if (k == 6) expect_out("indep", k, 5'b01010, 5'b01010);
            else             expect_out("indep", k, 5'b01010, 5'b00000);
        end
        btn_in = 5'b00000;
        for (int k = 1; k <= 6; k++) tick();
        expect_out("indep_release", 6, 5'b00000, 5'b00000);
    endtask

    task automatic test_min_param;
        btn_in1[3] = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            checks++;
            if ((k < 3  && (btn_level1 !== 5'b00000 || btn_pulse1 !== 5'b00000)) ||
                (k == 3 && (btn_level1 !== 5'b01000 || btn_pulse1 !== 5'b01000)) ||
                (k == 4 && (btn_level1 !== 5'b01000 || btn_pulse1 !== 5'b00000))) begin
                errors++;
                $display("FAIL min_param_press edge %0d: level=%b pulse=%b", k, btn_level1, btn_pulse1);
            end
        end
        btn_in1[3] = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            checks++;
            if (btn_pulse1 !== 5'b00000 || btn_level1 !== ((k < 3) ? 5'b01000 : 5'b00000)) begin
                errors++;
                $display("FAIL min_param_release edge %0d: level=%b pulse=%b", k, btn_level1, btn_pulse1);
            end
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst     = 1'b1;
        btn_in  = 5'b00000;
        btn_in1 = 5'b00000;
        tick();
        tick();
        rst = 1'b0;
        tick();
        test_reset();
        test_clean_press();
        test_bounce();
        test_reset_mid_count();
        test_independence();
        test_min_param();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
